mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
- Memory-side stage directly downstream of the processor control FSM.
- Takes the FSM's single-cycle memory request (address from PC/Reg mux, write strobe, data) and runs it as a multi-cycle transaction on a narrow 8-bit bidirectional external bus (address sent as bytes, then data).
- Returns read data (instruction or cell value) and a busy flag; the top level gates the FSM's `en` with `~busy`.

Parameters:
- ADDR_W, 16, address width. Legal values: 8 or 16. With 8, the ADDR_HI phase is skipped.
- WAIT_CYCLES, 1, fixed wait-state cycles between the address and data phases. Range 0..15; 0 skips WAIT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nreset  in  1  asynchronous active-low reset.
- req  in  1  transaction request, sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- addr  in  ADDR_W  byte address; captured with req.
- wdata  in  8  write data; captured with req.
- rdata  out  8  read data register; valid from the done cycle until the next read completes.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high while a transaction is in progress (state not IDLE and not DONE).
- bus_in  in  8  external bus input pins.
- bus_out  out  8  external bus output value.
- bus_oe  out  8  output enables; all 1s or all 0s.
- bus_ctrl  out  2  phase code: 00 idle, 01 addr low byte, 10 addr high byte, 11 data phase.
- bus_we  out  1  high during the data phase of a write.

Behaviour:
- Reset (nreset low, asynchronous):
  - State goes to IDLE.
  - rdata=0, done=0, busy=0, bus_out=0, bus_oe=0, bus_ctrl=00, bus_we=0, wait counter=0, capture registers=0.
  - Applies mid-transaction: the transaction is abandoned and no done pulse is issued.
- Output style: Moore. All outputs are decoded from registered state and registers, with no combinational path from req to any output.
- States: IDLE, ADDR_LO, ADDR_HI, WAIT, DATA, DONE.
- IDLE:
  - bus_ctrl=00, bus_oe=0.
  - If req=1 at a clock edge: capture addr, we and wdata, then go to ADDR_LO.
- ADDR_LO:
  - bus_ctrl=01, bus_out=addr[7:0], bus_oe=FF.
  - Next state is ADDR_HI if ADDR_W=16, otherwise WAIT (or DATA when WAIT_CYCLES=0).
- ADDR_HI:
  - bus_ctrl=10, bus_out=addr[15:8], bus_oe=FF.
  - Next state is WAIT, or DATA when WAIT_CYCLES=0.
- WAIT:
  - bus_ctrl=11, bus_oe=0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle; leave to DATA when the counter is 0.
- DATA, write:
  - bus_ctrl=11, bus_out=wdata, bus_oe=FF, bus_we=1.
- DATA, read:
  - bus_ctrl=11, bus_oe=0.
  - rdata <= bus_in at the closing edge of DATA.
- DONE:
  - done=1, busy=0, bus_ctrl=00, bus_oe=0.
  - Next state is IDLE unconditionally; req is not accepted in DONE.
- Latency: req accepted at edge k gives done high in cycle k + 2 + (ADDR_W==16) + WAIT_CYCLES + 1. With defaults that is cycle k+5.
- Minimum spacing between two accepted requests is latency + 1 cycles.
- req held high continuously starts a new transaction on the first IDLE edge after DONE.
- req toggling while busy is ignored; captured values stay stable for the whole transaction.
- rdata is unchanged by write transactions.
- busy rises in the cycle after acceptance. The FSM holds req/addr stable until done, so no request is lost.

Optional Feature:
- Macro: MEM_BUS_RDY_EN.
- Defined:
  - Adds input port bus_rdy (1 bit).
  - WAIT runs its WAIT_CYCLES minimum, then holds until bus_rdy=1 is sampled.
  - With WAIT_CYCLES=0, WAIT is still entered for one cycle and then holds for bus_rdy.
  - Then DATA proceeds as normal; there is no timeout.
  - Reset still aborts a hold.
- Undefined: no bus_rdy port; fixed wait only.

Test Plan:
- Reset then idle: after nreset release with req=0 for 10 cycles -> bus_ctrl=00, bus_oe=0, busy=0, done=0, rdata=00.
- Read, defaults: req=1 we=0 addr=0x1234 at edge 0, bus_in=0x2B during DATA -> ctrl sequence 01(bus_out 34), 10(12), 11 wait, 11 data. done high in cycle 5, rdata=0x2B.
- Write: we=1 addr=0x0005 wdata=0xA7 -> DATA cycle has bus_out=A7, bus_oe=FF, bus_we=1. done pulses one cycle, rdata is unchanged from the prior value.
- Parameters ADDR_W=8, WAIT_CYCLES=0: read addr=0x3C -> ctrl 01 then 11, done in cycle 3. Back-to-back with req held high gives a second ADDR_LO in cycle 5.
- Reset mid-op: nreset low during ADDR_HI -> all outputs 0 immediately (asynchronous), no done. The next req runs a full transaction correctly.
- MEM_BUS_RDY_EN: bus_rdy held 0 for 6 cycles -> state remains WAIT with busy=1. bus_rdy=1 -> DATA next cycle, then done.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
// Request and external byte-bus signals of mem_bus_ctrl.
// Carries bus_rdy only when MEM_BUS_RDY_EN is defined.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              done;
  logic              busy;
  logic [7:0]        bus_in;
  logic [7:0]        bus_out;
  logic [7:0]        bus_oe;
  logic [1:0]        bus_ctrl;
  logic              bus_we;
`ifdef MEM_BUS_RDY_EN
  logic              bus_rdy;

  modport master (
    output req, we, addr, wdata, bus_in, bus_rdy,
    input  rdata, done, busy,
    input  bus_out, bus_oe, bus_ctrl, bus_we
  );

  modport slave (
    input  req, we, addr, wdata, bus_in, bus_rdy,
    output rdata, done, busy,
    output bus_out, bus_oe, bus_ctrl, bus_we
  );
`else
  modport master (
    output req, we, addr, wdata, bus_in,
    input  rdata, done, busy,
    input  bus_out, bus_oe, bus_ctrl, bus_we
  );

  modport slave (
    input  req, we, addr, wdata, bus_in,
    output rdata, done, busy,
    output bus_out, bus_oe, bus_ctrl, bus_we
  );
`endif
endinterface

// File: rtl/mem_bus_ctrl.sv
// Runs single-cycle memory requests as byte-serial bus transactions.
// Define MEM_BUS_RDY_EN to extend WAIT until bus_rdy is sampled high.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            nreset,
  mem_bus_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_LO,
    ADDR_HI,
    WAIT,
    DATA,
    DONE
  } state_t;

  localparam bit HAS_HI = (ADDR_W > 8);
  localparam logic [3:0] CNT_LD =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

`ifdef MEM_BUS_RDY_EN
  localparam bit SKIP_WAIT = 1'b0;
  logic rdy;
  assign rdy = bus.bus_rdy;
`else
  localparam bit SKIP_WAIT = (WAIT_CYCLES == 0);
  logic rdy;
  assign rdy = 1'b1;
`endif

  state_t            st;
  state_t            st_nx;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rdata_q;
  logic [3:0]        cnt;
  logic [15:0]       addr_ext;

  assign addr_ext  = 16'(addr_q);
  assign bus.rdata = rdata_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      st      <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      cnt     <= 4'd0;
    end else begin
      st <= st_nx;
      if (st == IDLE && bus.req) begin
        addr_q  <= bus.addr;
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
      end
      if (st_nx == WAIT && st != WAIT)
        cnt <= CNT_LD;
      else if (st == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (st == DATA && !we_q)
        rdata_q <= bus.bus_in;
    end
  end

  always_comb begin
    st_nx        = st;
    bus.bus_out  = 8'h00;
    bus.bus_oe   = 8'h00;
    bus.bus_ctrl = 2'b00;
    bus.bus_we   = 1'b0;
    bus.done     = 1'b0;
    bus.busy     = 1'b1;
    unique case (st)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.req)
          st_nx = ADDR_LO;
      end
      ADDR_LO: begin
        bus.bus_ctrl = 2'b01;
        bus.bus_out  = addr_ext[7:0];
        bus.bus_oe   = 8'hFF;
        if (HAS_HI)
          st_nx = ADDR_HI;
        else
          st_nx = SKIP_WAIT ? DATA : WAIT;
      end
      ADDR_HI: begin
        bus.bus_ctrl = 2'b10;
        bus.bus_out  = addr_ext[15:8];
        bus.bus_oe   = 8'hFF;
        st_nx        = SKIP_WAIT ? DATA : WAIT;
      end
      WAIT: begin
        bus.bus_ctrl = 2'b11;
        if (cnt == 4'd0 && rdy)
          st_nx = DATA;
      end
      DATA: begin
        bus.bus_ctrl = 2'b11;
        if (we_q) begin
          bus.bus_out = wdata_q;
          bus.bus_oe  = 8'hFF;
          bus.bus_we  = 1'b1;
        end
        st_nx = DONE;
      end
      DONE: begin
        bus.busy = 1'b0;
        bus.done = 1'b1;
        st_nx    = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: default build and ADDR_W=8,
// WAIT_CYCLES=0 build side by side; observation word is ctrl|oe|out|we|busy|done.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic nreset;
  int   vec  = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.ADDR_W(16)) ifa ();
  mem_bus_ctrl_if #(.ADDR_W(8))  ifb ();

  mem_bus_ctrl u_a (
    .clk    (clk),
    .nreset (nreset),
    .bus    (ifa.slave)
  );

  mem_bus_ctrl #(
    .ADDR_W      (8),
    .WAIT_CYCLES (0)
  ) u_b (
    .clk    (clk),
    .nreset (nreset),
    .bus    (ifb.slave)
  );

  function automatic logic [20:0] obs_a();
    return {ifa.bus_ctrl, ifa.bus_oe, ifa.bus_out,
            ifa.bus_we, ifa.busy, ifa.done};
  endfunction

  function automatic logic [20:0] obs_b();
    return {ifb.bus_ctrl, ifb.bus_oe, ifb.bus_out,
            ifb.bus_we, ifb.busy, ifb.done};
  endfunction

  task automatic idle_inputs();
    ifa.req = 1'b0; ifa.we = 1'b0;
    ifa.addr = 16'h0; ifa.wdata = 8'h00;
    ifa.bus_in = 8'h00;
    ifb.req = 1'b0; ifb.we = 1'b0;
    ifb.addr = 8'h0; ifb.wdata = 8'h00;
    ifb.bus_in = 8'h00;
`ifdef MEM_BUS_RDY_EN
    ifa.bus_rdy = 1'b1;
    ifb.bus_rdy = 1'b1;
`endif
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (10) @(negedge clk);
    vec++;
    if (obs_a() !== 21'h0) begin
      miss++;
      $display("FAIL reset_a_outs: got %h want %h", obs_a(), 21'h0);
    end
    vec++;
    if (ifa.rdata !== 8'h00) begin
      miss++;
      $display("FAIL reset_a_rdata: got %h want 00", ifa.rdata);
    end
    vec++;
    if (obs_b() !== 21'h0) begin
      miss++;
      $display("FAIL reset_b_outs: got %h want %h", obs_b(), 21'h0);
    end
    vec++;
    if (ifb.rdata !== 8'h00) begin
      miss++;
      $display("FAIL reset_b_rdata: got %h want 00", ifb.rdata);
    end
  endtask

  task automatic test_read(input logic [15:0] a, input logic [7:0] din);
    logic [20:0] e [6];
    e = '{
      {2'b01, 8'hFF, a[7:0],  3'b010},
      {2'b10, 8'hFF, a[15:8], 3'b010},
      {2'b11, 8'h00, 8'h00,   3'b010},
      {2'b11, 8'h00, 8'h00,   3'b010},
      {2'b00, 8'h00, 8'h00,   3'b001},
      21'h0
    };
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b0;
    ifa.addr = a; ifa.wdata = 8'h00;
    ifa.bus_in = din;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (obs_a() !== e[c]) begin
        miss++;
        $display("FAIL read_c%0d: got %h want %h", c + 1, obs_a(), e[c]);
      end
      if (c == 0) begin
        // scramble inputs to prove the captured request is used
        ifa.req = 1'b0; ifa.addr = ~a;
        ifa.we = 1'b1; ifa.wdata = 8'h55;
      end
    end
    vec++;
    if (ifa.rdata !== din) begin
      miss++;
      $display("FAIL read_rdata: got %h want %h", ifa.rdata, din);
    end
    ifa.we = 1'b0;
    ifa.bus_in = 8'h00;
  endtask

  task automatic test_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [7:0] prev);
    logic [20:0] e [6];
    e = '{
      {2'b01, 8'hFF, a[7:0],  3'b010},
      {2'b10, 8'hFF, a[15:8], 3'b010},
      {2'b11, 8'h00, 8'h00,   3'b010},
      {2'b11, 8'hFF, d,       3'b110},
      {2'b00, 8'h00, 8'h00,   3'b001},
      21'h0
    };
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b1;
    ifa.addr = a; ifa.wdata = d;
    ifa.bus_in = 8'h99;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (obs_a() !== e[c]) begin
        miss++;
        $display("FAIL write_c%0d: got %h want %h", c + 1, obs_a(), e[c]);
      end
      if (c == 0) begin
        ifa.req = 1'b0; ifa.we = 1'b0;
        ifa.wdata = 8'h3C;
      end
    end
    vec++;
    if (ifa.rdata !== prev) begin
      miss++;
      $display("FAIL write_rdata_kept: got %h want %h", ifa.rdata, prev);
    end
    ifa.bus_in = 8'h00;
  endtask

  task automatic test_addr8_back_to_back();
    logic [20:0] e [6];
`ifdef MEM_BUS_RDY_EN
    e = '{
      {2'b01, 8'hFF, 8'h3C, 3'b010},
      {2'b11, 8'h00, 8'h00, 3'b010},
      {2'b11, 8'h00, 8'h00, 3'b010},
      {2'b00, 8'h00, 8'h00, 3'b001},
      21'h0,
      {2'b01, 8'hFF, 8'h3C, 3'b010}
    };
`else
    e = '{
      {2'b01, 8'hFF, 8'h3C, 3'b010},
      {2'b11, 8'h00, 8'h00, 3'b010},
      {2'b00, 8'h00, 8'h00, 3'b001},
      21'h0,
      {2'b01, 8'hFF, 8'h3C, 3'b010},
      {2'b11, 8'h00, 8'h00, 3'b010}
    };
`endif
    @(negedge clk);
    ifb.req = 1'b1; ifb.we = 1'b0;
    ifb.addr = 8'h3C; ifb.bus_in = 8'hC3;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (obs_b() !== e[c]) begin
        miss++;
        $display("FAIL a8_c%0d: got %h want %h", c + 1, obs_b(), e[c]);
      end
    end
    ifb.req = 1'b0;
    repeat (6) @(negedge clk);
    vec++;
    if (obs_b() !== 21'h0) begin
      miss++;
      $display("FAIL a8_idle: got %h want %h", obs_b(), 21'h0);
    end
    vec++;
    if (ifb.rdata !== 8'hC3) begin
      miss++;
      $display("FAIL a8_rdata: got %h want c3", ifb.rdata);
    end
    ifb.bus_in = 8'h00;
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    ifa.req = 1'b1; ifa.we = 1'b0;
    ifa.addr = 16'h1234; ifa.bus_in = 8'h77;
    @(negedge clk);
    ifa.req = 1'b0;
    @(negedge clk);
    vec++;
    if (obs_a() !== {2'b10, 8'hFF, 8'h12, 3'b010}) begin
      miss++;
      $display("FAIL mid_addr_hi: got %h want %h", obs_a(),
               {2'b10, 8'hFF, 8'h12, 3'b010});
    end
    #2 nreset = 1'b0;
    #1;
    vec++;
    if (obs_a() !== 21'h0) begin
      miss++;
      $display("FAIL mid_async_outs: got %h want %h", obs_a(), 21'h0);
    end
    vec++;
    if (ifa.rdata !== 8'h00) begin
      miss++;
      $display("FAIL mid_async_rdata: got %h want 00", ifa.rdata);
    end
    dones = 0;
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifa.done === 1'b1) dones++;
    end
    vec++;
    if (dones !== 0) begin
      miss++;
      $display("FAIL mid_no_done: got %0d pulses want 0", dones);
    end
    ifa.bus_in = 8'h00;
    test_read(16'hABCD, 8'h5A);
  endtask

`ifdef MEM_BUS_RDY_EN
  task automatic test_rdy_hold();
    logic [20:0] w;
    w = {2'b11, 8'h00, 8'h00, 3'b010};
    @(negedge clk);
    ifa.bus_rdy = 1'b0;
    ifa.req = 1'b1; ifa.we = 1'b0;
    ifa.addr = 16'h0042; ifa.bus_in = 8'hE1;
    @(negedge clk);
    ifa.req = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vec++;
      if (obs_a() !== w) begin
        miss++;
        $display("FAIL rdy_hold_c%0d: got %h want %h", c, obs_a(), w);
      end
    end
    ifa.bus_rdy = 1'b1;
    @(negedge clk);
    vec++;
    if (obs_a() !== w) begin
      miss++;
      $display("FAIL rdy_data: got %h want %h", obs_a(), w);
    end
    @(negedge clk);
    vec++;
    if (obs_a() !== {2'b00, 8'h00, 8'h00, 3'b001}) begin
      miss++;
      $display("FAIL rdy_done: got %h want %h", obs_a(),
               {2'b00, 8'h00, 8'h00, 3'b001});
    end
    vec++;
    if (ifa.rdata !== 8'hE1) begin
      miss++;
      $display("FAIL rdy_rdata: got %h want e1", ifa.rdata);
    end
    ifa.bus_in = 8'h00;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read(16'h1234, 8'h2B);
    test_write(16'h0005, 8'hA7, 8'h2B);
    test_addr8_back_to_back();
    test_reset_mid();
`ifdef MEM_BUS_RDY_EN
    test_rdy_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
